// File: rtl/alu_exec.sv
// Three-state (IDLE/EXEC/WB) instruction sequencer around an external 4-bit ALU with a 4x4 register file and carry flag.
// Optional zero flag output enabled by defining ALU_EXEC_ZFLAG_EN.
module alu_exec #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [1:0]        instr_dst,
  input  logic [1:0]        instr_src,
  input  logic [DATA_W-1:0] instr_imm,
  input  logic              instr_use_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_sel,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_cout,
  output logic              done,
  input  logic [1:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
`ifdef ALU_EXEC_ZFLAG_EN
  output logic              z_flag,
`endif
  output logic              c_flag
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] EXEC = 2'b01;
  localparam logic [1:0] WB   = 2'b10;

  logic [1:0]        state;
  logic [2:0]        op_p0;
  logic [1:0]        dst_p0;
  logic [1:0]        src_p0;
  logic [DATA_W-1:0] imm_p0;
  logic              use_imm_p0;
  logic [DATA_W-1:0] res_p1;
  logic              cout_p1;
  logic [DATA_W-1:0] regs [4];
  logic              c_q;
  logic [DATA_W-1:0] opnd_b;
  logic              wr_en;
  logic              c_en;

  assign opnd_b      = use_imm_p0 ? imm_p0 : regs[src_p0];
  assign wr_en       = (state == WB) && (op_p0[2:1] != 2'b00);
  assign c_en        = (state == WB) && (op_p0[2:1] == 2'b01);
  assign instr_ready = (state == IDLE);
  assign done        = (state == WB);
  assign rd_data     = regs[rd_addr];
  assign c_flag      = c_q;

  // Operands are presented to the ALU only while in EXEC; move (111) routes B onto A.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = 3'b000;
    alu_cin = 1'b0;
    if (state == EXEC) begin
      alu_sel = op_p0;
      alu_cin = c_q;
      alu_b   = opnd_b;
      alu_a   = (op_p0 == 3'b111) ? opnd_b : regs[dst_p0];
    end
  end

  // Stage p0: instruction fields latched on acceptance
  always_ff @(posedge clk) begin
    if (state == IDLE && instr_valid) begin
      op_p0      <= instr_op;
      dst_p0     <= instr_dst;
      src_p0     <= instr_src;
      imm_p0     <= instr_imm;
      use_imm_p0 <= instr_use_imm;
    end
  end

  // Stage p1: ALU result captured at the edge ending EXEC
  always_ff @(posedge clk) begin
    if (state == EXEC) begin
      res_p1  <= alu_out;
      cout_p1 <= alu_cout;
    end
  end

  // Control and architectural state; reset wins over any pending write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      c_q   <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE:    if (instr_valid) state <= EXEC;
        EXEC:    state <= WB;
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
      if (wr_en) regs[dst_p0] <= res_p1;
      if (c_en)  c_q <= cout_p1;
    end
  end

`ifdef ALU_EXEC_ZFLAG_EN
  always_ff @(posedge clk) begin
    if (rst)        z_flag <= 1'b0;
    else if (wr_en) z_flag <= (res_p1 == '0);
  end
`endif

endmodule
